multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RISC-V core. It is the successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath strobes.
- Waits on a shared instruction/data memory via a ready handshake, with a parametrised timeout.
- Sits between the instruction register (opcode source) and the multi-cycle datapath muxes and enables.

Parameters:
- ALU_OP_W, 3: width of alu_op_o. Codes are zero-extended when wider than 3.
- TIMEOUT_CYCLES, 15: max consecutive mem_ready_i-low cycles in FETCH or MEM before abort. Legal range 1..255.
- CNT_W, 8: wait-counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  synchronous, active-low reset
- op_i  in  7  opcode from IR; stable from DECODE until the next FETCH
- mem_ready_i  in  1  memory completes the current access this cycle
- pc_write_o  out  1  PC register load enable
- pc_src_o  out  2  00 = PC+4, 01 = branch/JAL target (PC+imm), 10 = JALR target (rs1+imm)
- branch_o  out  1  conditional PC write; datapath ANDs it with the compare result
- iord_o  out  1  0 = memory address from PC, 1 = from ALU result register
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  IR and old-PC load enable
- reg_write_o  out  1  register file write enable
- mem_to_reg_o  out  2  00 = ALU result, 01 = memory data, 10 = old PC+4 (link)
- alu_src_o  out  1  0 = rs2, 1 = immediate
- alu_op_o  out  ALU_OP_W  ALU operation class
- mem_err_o  out  1  one-cycle pulse on memory timeout
- illegal_o  out  1  illegal opcode flag (see Optional Feature)
- state_o  out  3  current state, for debug

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are Moore, decoded from the state register plus op_i. Every strobe is 0 unless listed for that state.
- Reset (reset_n_i low at a rising edge):
  - state becomes FETCH and the wait counter clears.
  - mem_err_o and illegal_o clear.
  - Reset mid-instruction aborts the instruction with no further strobes.
  - While reset_n_i is low, all outputs are forced to 0.
- FETCH:
  - mem_read_o = 1, iord_o = 0.
  - On mem_ready_i: ir_write_o = 1, pc_write_o = 1, pc_src_o = 00, next state DECODE.
  - Otherwise stay in FETCH and increment the counter.
- DECODE:
  - No strobes.
  - Known opcode -> EXEC.
  - Unknown opcode -> see Optional Feature.
- EXEC: alu_op_o and alu_src_o per class.
  - R (0x33): alu_op 000, src 0.
  - I-logic (0x13): 001, src 1.
  - LOAD (0x03): 001, src 1.
  - STORE (0x23): 110, src 1.
  - LUI (0x37): 100, src 1.
  - BRANCH (0x63): 111, src 0, branch_o = 1, pc_src_o = 01.
  - JAL (0x6F): 101, src 1, pc_write_o = 1, pc_src_o = 01.
  - JALR (0x67): 101, src 1, pc_write_o = 1, pc_src_o = 10.
- EXEC next state: LOAD/STORE -> MEM; BRANCH -> FETCH; all others -> WB.
- MEM:
  - iord_o = 1.
  - mem_read_o = 1 for LOAD; mem_write_o = 1 for STORE.
  - Request is held until mem_ready_i.
  - On ready: LOAD -> WB, STORE -> FETCH.
  - Otherwise stay in MEM and increment the counter.
- WB:
  - reg_write_o = 1.
  - mem_to_reg_o: 01 for LOAD, 10 for JAL/JALR, else 00.
  - Next state FETCH.
- Cycle counts with zero-wait memory (ready in the first cycle):
  - BRANCH: 3 cycles.
  - R, I, LUI, STORE, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Clears on every state change.
  - Increments each FETCH/MEM cycle with mem_ready_i = 0; saturates and never wraps.
  - Timeout occurs when the counter equals TIMEOUT_CYCLES and mem_ready_i = 0.
- On timeout:
  - All strobes are 0 that cycle, including no pc_write or ir_write.
  - mem_err_o = 1 for exactly 1 cycle.
  - Next state FETCH with the counter cleared.
  - A FETCH timeout retries the same PC. A MEM timeout abandons the instruction.
- mem_ready_i high in the same cycle the counter reaches TIMEOUT_CYCLES counts as success; ready wins.
- mem_ready_i is ignored in DECODE, EXEC and WB.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE moves to TRAP.
  - TRAP drives all strobes to 0, sets illegal_o = 1 (sticky), and stays in TRAP until reset.
  - state_o = 5 while in TRAP.
- Undefined:
  - An unknown opcode in DECODE goes straight to FETCH, acting as a NOP with 2-cycle latency.
  - The TRAP state is not generated and illegal_o is tied to 0.

Test Plan:
- Reset, then op_i = 0x33, mem_ready_i = 1 always -> state_o sequence 0,1,2,4,0. reg_write_o high only in cycle 4. alu_op_o = 000 in EXEC.
- op_i = 0x03, mem_ready_i low for 3 cycles in MEM -> mem_read_o with iord_o = 1 held for 4 cycles. WB has mem_to_reg_o = 01. Total 8 cycles.
- op_i = 0x67 -> EXEC has pc_write_o = 1, pc_src_o = 10. WB has mem_to_reg_o = 10, reg_write_o = 1.
- TIMEOUT_CYCLES = 4, mem_ready_i held 0 in FETCH -> mem_err_o pulses once in the 5th FETCH cycle. No ir_write_o. FETCH restarts with counter 0.
- Second timeout case: mem_ready_i rises exactly on the timeout cycle -> no mem_err_o, transition to DECODE.
- op_i = 0x7F with ILLEGAL_TRAP_EN defined -> state_o = 5 and illegal_o = 1 held. reset_n_i low for 1 cycle returns to FETCH with illegal_o = 0.
- op_i = 0x7F without ILLEGAL_TRAP_EN -> DECODE goes to FETCH with no strobes.
- STORE with reset_n_i low in MEM -> mem_write_o = 0 in the next cycle, state_o = 0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control FSM for the RISC-V core.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes. FETCH and MEM wait on a shared memory through mem_ready_i
// and abort after TIMEOUT_CYCLES consecutive not-ready cycles.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an unknown opcode
// locks the FSM in TRAP until reset. When it is undefined, an unknown opcode
// behaves as a NOP.
module multicycle_control #(
  parameter int ALU_OP_W       = 3,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [6:0]          op_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                branch_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                alu_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                mem_err_o,
  output logic                illegal_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             known_op;
  logic             is_load;
  logic             is_store;
  logic             waiting;
  logic             timeout;
  logic [2:0]       alu_code;

  assign known_op = op_i inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                 OP_LUI, OP_BRANCH, OP_JAL, OP_JALR};
  assign is_load  = (op_i == OP_LOAD);
  assign is_store = (op_i == OP_STORE);

  // A memory-facing state that is still waiting. When the counter has reached
  // the limit in such a cycle, the access is abandoned. A ready in that same
  // cycle is still a success, because waiting is then low.
  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready_i;
  assign timeout = waiting && (wait_cnt == TIMEOUT_VAL);

  // Next-state selection from the current state, the opcode and the memory handshake.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    next_state = state;
    case (state)
      S_FETCH: begin
        if (mem_ready_i) next_state = S_DECODE;
        else if (timeout) next_state = S_FETCH;
      end
      S_DECODE: begin
        if (known_op) next_state = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else next_state = S_TRAP;
`else
        else next_state = S_FETCH;
`endif
      end
      S_EXEC: begin
        if (is_load || is_store) next_state = S_MEM;
        else if (op_i == OP_BRANCH) next_state = S_FETCH;
        else next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready_i) next_state = is_load ? S_WB : S_FETCH;
        else if (timeout) next_state = S_FETCH;
      end
      S_WB: next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: next_state = S_TRAP;
`endif
      default: next_state = S_FETCH;
    endcase
  end

  // State register and saturating wait counter, with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    if (!reset_n_i) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || timeout) wait_cnt <= '0;
      else if (waiting && (wait_cnt != CNT_MAX)) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Moore strobes decoded from state and opcode. All outputs are held at 0 during reset.
  always_comb begin
    pc_write_o   = 1'b0;
    pc_src_o     = 2'b00;
    branch_o     = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 2'b00;
    alu_src_o    = 1'b0;
    alu_code     = 3'b000;
    mem_err_o    = 1'b0;
    illegal_o    = 1'b0;
    state_o      = 3'd0;
    if (reset_n_i) begin
      state_o = state;
      case (state)
        S_FETCH: begin
          if (timeout) begin
            mem_err_o = 1'b1;
          end else begin
            mem_read_o = 1'b1;
            if (mem_ready_i) begin
              ir_write_o = 1'b1;
              pc_write_o = 1'b1;
            end
          end
        end
        S_EXEC: begin
          case (op_i)
            OP_R: alu_code = 3'b000;
            OP_I, OP_LOAD: begin
              alu_code  = 3'b001;
              alu_src_o = 1'b1;
            end
            OP_STORE: begin
              alu_code  = 3'b110;
              alu_src_o = 1'b1;
            end
            OP_LUI: begin
              alu_code  = 3'b100;
              alu_src_o = 1'b1;
            end
            OP_BRANCH: begin
              alu_code = 3'b111;
              branch_o = 1'b1;
              pc_src_o = 2'b01;
            end
            OP_JAL: begin
              alu_code   = 3'b101;
              alu_src_o  = 1'b1;
              pc_write_o = 1'b1;
              pc_src_o   = 2'b01;
            end
            OP_JALR: begin
              alu_code   = 3'b101;
              alu_src_o  = 1'b1;
              pc_write_o = 1'b1;
              pc_src_o   = 2'b10;
            end
            default: alu_code = 3'b000;
          endcase
        end
        S_MEM: begin
          if (timeout) begin
            mem_err_o = 1'b1;
          end else begin
            iord_o      = 1'b1;
            mem_read_o  = is_load;
            mem_write_o = is_store;
          end
        end
        S_WB: begin
          reg_write_o = 1'b1;
          if (is_load) mem_to_reg_o = 2'b01;
          else if ((op_i == OP_JAL) || (op_i == OP_JALR)) mem_to_reg_o = 2'b10;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: illegal_o = 1'b1;
`endif
        default: ;
      endcase
    end
    alu_op_o = ALU_OP_W'(alu_code);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// A generator expands each instruction into the cycle trace that the control
// rules require. This uses fetch/memory wait counts, timeouts and reset aborts.
// The driver applies each cycle's inputs and queues the expected output vector.
// The monitor pops one entry on every falling edge and compares it.
module tb_multicycle_control;

  localparam int TO = 4;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_err;
    logic       illegal;
    logic [2:0] state;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic       ready;
    logic [6:0] op;
    out_t       exp;
  } item_t;

  typedef enum {K_ILL, K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR} kind_t;

  typedef struct {
    kind_t      kind;
    logic [2:0] alu_op;
    logic       alu_src;
  } cls_t;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       branch;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic       alu_src;
  logic [2:0] alu_op;
  logic       mem_err;
  logic       illegal;
  logic [2:0] state;
  out_t       act;

  item_t plan[$];
  out_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  logic [6:0] known_ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h63, 7'h6F, 7'h67};

  multicycle_control #(
    .ALU_OP_W(3),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .op_i(op),
    .mem_ready_i(mem_ready),
    .pc_write_o(pc_write),
    .pc_src_o(pc_src),
    .branch_o(branch),
    .iord_o(iord),
    .mem_read_o(mem_read),
    .mem_write_o(mem_write),
    .ir_write_o(ir_write),
    .reg_write_o(reg_write),
    .mem_to_reg_o(mem_to_reg),
    .alu_src_o(alu_src),
    .alu_op_o(alu_op),
    .mem_err_o(mem_err),
    .illegal_o(illegal),
    .state_o(state)
  );

  assign act = {pc_write, pc_src, branch, iord, mem_read, mem_write, ir_write,
                reg_write, mem_to_reg, alu_src, alu_op, mem_err, illegal, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction class table: the opcode determines the ALU code, the source and the flow.
  function automatic cls_t classify(input logic [6:0] o);
    cls_t c;
    c.kind = K_ILL; c.alu_op = 3'b000; c.alu_src = 1'b0;
    case (o)
      7'h33: begin c.kind = K_ALU;    c.alu_op = 3'b000; c.alu_src = 1'b0; end
      7'h13: begin c.kind = K_ALU;    c.alu_op = 3'b001; c.alu_src = 1'b1; end
      7'h03: begin c.kind = K_LOAD;   c.alu_op = 3'b001; c.alu_src = 1'b1; end
      7'h23: begin c.kind = K_STORE;  c.alu_op = 3'b110; c.alu_src = 1'b1; end
      7'h37: begin c.kind = K_ALU;    c.alu_op = 3'b100; c.alu_src = 1'b1; end
      7'h63: begin c.kind = K_BRANCH; c.alu_op = 3'b111; c.alu_src = 1'b0; end
      7'h6F: begin c.kind = K_JAL;    c.alu_op = 3'b101; c.alu_src = 1'b1; end
      7'h67: begin c.kind = K_JALR;   c.alu_op = 3'b101; c.alu_src = 1'b1; end
      default: c.kind = K_ILL;
    endcase
    return c;
  endfunction

  function automatic out_t z(input logic [2:0] st);
    out_t v = '0;
    v.state = st;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic push(input logic rst_n, input logic rdy, input logic [6:0] o, input out_t e);
    item_t it;
    it.rst_n = rst_n; it.ready = rdy; it.op = o; it.exp = e;
    plan.push_back(it);
  endtask

  // Expand one instruction into its expected cycle trace.
  // fs/ms are memory not-ready cycle counts. A value above TO means a timeout.
  task automatic gen_instr(input logic [6:0] o, input int fs, input int ms, input bit abort_mem);
    cls_t c = classify(o);
    out_t v;
    int   s = fs;
    bit   done = 1'b0;
    while (!done) begin
      v = z(3'd0); v.mem_read = 1'b1;
      if (s > TO) begin
        repeat (TO) push(1'b1, 1'b0, o, v);
        v = z(3'd0); v.mem_err = 1'b1;
        push(1'b1, 1'b0, o, v);
        s = $urandom_range(TO, 0);
      end else begin
        repeat (s) push(1'b1, 1'b0, o, v);
        v.ir_write = 1'b1; v.pc_write = 1'b1;
        push(1'b1, 1'b1, o, v);
        done = 1'b1;
      end
    end
    push(1'b1, rb(), o, z(3'd1));
    if (c.kind == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      v = z(3'd5); v.illegal = 1'b1;
      repeat ($urandom_range(4, 1)) push(1'b1, rb(), o, v);
      push(1'b0, rb(), o, z(3'd0));
`endif
      return;
    end
    v = z(3'd2); v.alu_op = c.alu_op; v.alu_src = c.alu_src;
    case (c.kind)
      K_BRANCH: begin v.branch = 1'b1; v.pc_src = 2'b01; end
      K_JAL:    begin v.pc_write = 1'b1; v.pc_src = 2'b01; end
      K_JALR:   begin v.pc_write = 1'b1; v.pc_src = 2'b10; end
      default: ;
    endcase
    push(1'b1, rb(), o, v);
    if (c.kind == K_BRANCH) return;
    if ((c.kind == K_LOAD) || (c.kind == K_STORE)) begin
      v = z(3'd3); v.iord = 1'b1;
      v.mem_read  = (c.kind == K_LOAD);
      v.mem_write = (c.kind == K_STORE);
      if (abort_mem) begin
        push(1'b1, 1'b0, o, v);
        push(1'b0, rb(), o, z(3'd0));
        return;
      end
      if (ms > TO) begin
        repeat (TO) push(1'b1, 1'b0, o, v);
        v = z(3'd3); v.mem_err = 1'b1;
        push(1'b1, 1'b0, o, v);
        return;
      end
      repeat (ms) push(1'b1, 1'b0, o, v);
      push(1'b1, 1'b1, o, v);
      if (c.kind == K_STORE) return;
    end
    v = z(3'd4); v.reg_write = 1'b1;
    if (c.kind == K_LOAD) v.mem_to_reg = 2'b01;
    else if ((c.kind == K_JAL) || (c.kind == K_JALR)) v.mem_to_reg = 2'b10;
    push(1'b1, rb(), o, v);
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
               name, got, got.state, exp, exp.state);
    end
  endtask

  // Monitor: one expected vector per driven cycle, compared away from the active edge.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("cycle %0d", cyc), act, e);
        cyc++;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized instructions, then drive and drain.
  initial begin
    logic [6:0] o;
    int         fs;
    int         ms;
    bit         ab;
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    op        = 7'h00;
    repeat (3) push(1'b0, 1'b0, 7'h00, z(3'd0));
    gen_instr(7'h33, 0, 0, 1'b0);        // R, zero-wait
    gen_instr(7'h03, 0, 3, 1'b0);        // LOAD, three MEM waits
    gen_instr(7'h67, 0, 0, 1'b0);        // JALR
    gen_instr(7'h33, TO + 1, 0, 1'b0);   // FETCH timeout then retry
    gen_instr(7'h13, TO, 0, 1'b0);       // ready on the timeout cycle wins
    gen_instr(7'h03, 0, TO, 1'b0);       // MEM ready on the timeout cycle wins
    gen_instr(7'h23, 0, TO + 1, 1'b0);   // MEM timeout abandons STORE
    gen_instr(7'h7F, 0, 0, 1'b0);        // unknown opcode
    gen_instr(7'h23, 0, 0, 1'b1);        // reset while STORE is in MEM
    gen_instr(7'h6F, 0, 0, 1'b0);
    gen_instr(7'h63, 0, 0, 1'b0);
    gen_instr(7'h37, 0, 0, 1'b0);
    gen_instr(7'h23, 1, 2, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(7, 0) == 0) o = 7'($urandom_range(127, 0));
      else o = known_ops[$urandom_range(7, 0)];
      fs = ($urandom_range(3, 0) == 0) ? int'($urandom_range(TO + 2, 0)) : 0;
      ms = ($urandom_range(2, 0) == 0) ? int'($urandom_range(TO + 2, 0)) : 0;
      ab = ($urandom_range(15, 0) == 0);
      gen_instr(o, fs, ms, ab);
    end
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset_n   = plan[i].rst_n;
      mem_ready = plan[i].ready;
      op        = plan[i].op;
      sb.push_back(plan[i].exp);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog bound on the whole run.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
